// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I control definitions: FSM state encoding, opcodes, ALUOp codes.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_MEM   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // True for the opcode subset this core executes.
    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_ITYPE) ||
               (op == OP_LOAD)  || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: sequences a shared memory port, ALU and register
// file through FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       Opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       ALUOp,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t     state, state_nxt;
    logic [6:0] op_q;
    logic       retire;

    // ALU operand/op selection depends only on the latched opcode.
    logic       alu_src_q;
    logic [1:0] alu_op_q;
    always_comb begin
        alu_src_q = 1'b1;
        alu_op_q  = ALUOP_MEM;
        if (op_q == OP_RTYPE) begin
            alu_src_q = 1'b0;
            alu_op_q  = ALUOP_RTYPE;
        end else if (op_q == OP_ITYPE) begin
            alu_op_q  = ALUOP_ADD;
        end
    end

    // State register and opcode latch (opcode sampled only in DECODE).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            op_q  <= 7'd0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) op_q <= Opcode;
        end
    end

    // Retired-instruction counter; wraps silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) instret <= '0;
        else if (retire) instret <= instret + CNT_W'(1);
    end

    // Next-state and output decode; IRWrite/PCWrite are Mealy on mem_ready.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        ALUSrc    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        ALUOp     = 2'b00;
        illegal   = 1'b0;
        retire    = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = op_supported(Opcode) ? S_EXEC : S_TRAP;
            S_EXEC: begin
                ALUSrc    = alu_src_q;
                ALUOp     = alu_op_q;
                state_nxt = (op_q == OP_LOAD || op_q == OP_STORE) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                ALUSrc   = 1'b1;
                ALUOp    = ALUOP_MEM;
                MemRead  = (op_q == OP_LOAD);
                MemWrite = (op_q == OP_STORE);
                if (mem_ready) begin
                    // Stores finish here; loads still need write-back.
                    state_nxt = (op_q == OP_STORE) ? S_FETCH : S_WB;
                    retire    = (op_q == OP_STORE);
                end
            end
            S_WB: begin
                RegWrite  = 1'b1;
                MemtoReg  = (op_q == OP_LOAD);
                ALUSrc    = alu_src_q;
                ALUOp     = alu_op_q;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_TRAP: illegal = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-level bench: each instruction expands into its
// expected per-cycle control trace, checked cycle by cycle.
module tb_multicycle_controller;

    localparam int CNT_W = 4;

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] I_OP  = 7'b0010011;
    localparam logic [6:0] LD_OP = 7'b0000011;
    localparam logic [6:0] ST_OP = 7'b0100011;
    localparam logic [6:0] BR_OP = 7'b1100011;

    // Output vector layout: {illegal, mem_req, IorD, IRWrite, PCWrite,
    //                        ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp}
    localparam logic [11:0] B_ILL  = 12'h800;
    localparam logic [11:0] B_REQ  = 12'h400;
    localparam logic [11:0] B_IORD = 12'h200;
    localparam logic [11:0] B_IRW  = 12'h100;
    localparam logic [11:0] B_PCW  = 12'h080;
    localparam logic [11:0] B_SRC  = 12'h040;
    localparam logic [11:0] B_M2R  = 12'h020;
    localparam logic [11:0] B_RW   = 12'h010;
    localparam logic [11:0] B_MRD  = 12'h008;
    localparam logic [11:0] B_MWR  = 12'h004;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [6:0]       Opcode;
    logic             mem_ready;
    logic             mem_req, IorD, IRWrite, PCWrite, ALUSrc, MemtoReg;
    logic             RegWrite, MemRead, MemWrite, illegal;
    logic [1:0]       ALUOp;
    logic [CNT_W-1:0] instret;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp),
        .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] outs();
        return {illegal, mem_req, IorD, IRWrite, PCWrite, ALUSrc, MemtoReg,
                RegWrite, MemRead, MemWrite, ALUOp};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs just after the edge, check mid-cycle, advance.
    task automatic cyc(input string tag, input logic [6:0] opc, input logic rdy,
                       input logic [11:0] exp);
        Opcode    = opc;
        mem_ready = rdy;
        #3;
        chk(tag, 32'(outs()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk(tag, 32'(instret), 32'(model_cnt % (1 << CNT_W)));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("reset_outs", 32'(outs()), 32'd0);
        chk("reset_instret", 32'(instret), 32'd0);
        model_cnt = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc("idle", 7'($urandom), 1'($urandom), 12'h000);
    endtask

    // ALU fields an instruction uses in EXEC/WB.
    function automatic logic [11:0] alu_bits(input logic [6:0] op);
        if (op == R_OP) return 12'h002;
        if (op == I_OP) return B_SRC;
        return B_SRC | 12'h001;
    endfunction

    // Run one instruction through its whole expected trace. rst_in_mem
    // aborts it with an asynchronous reset in the first MEM wait cycle.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input bit rst_in_mem);
        logic [11:0] mem_bits;
        for (int i = 0; i < fw; i++)
            cyc("fetch_wait", 7'($urandom), 1'b0, B_REQ | B_MRD);
        cyc("fetch_done", 7'($urandom), 1'b1, B_REQ | B_MRD | B_IRW | B_PCW);
        cyc("decode", op, 1'($urandom), 12'h000);
        if (!(op == R_OP || op == I_OP || op == LD_OP || op == ST_OP)) return;
        // Opcode is scrambled from here on; only the latched one may matter.
        cyc("exec", 7'($urandom), 1'($urandom), alu_bits(op));
        if (op == LD_OP || op == ST_OP) begin
            mem_bits = B_REQ | B_IORD | B_SRC | 12'h001 | ((op == LD_OP) ? B_MRD : B_MWR);
            if (rst_in_mem) begin
                Opcode    = 7'($urandom);
                mem_ready = 1'b0;
                #3;
                chk("mem_before_reset", 32'(outs()), 32'(mem_bits));
                do_reset();
                return;
            end
            for (int i = 0; i < mw; i++)
                cyc("mem_wait", 7'($urandom), 1'b0, mem_bits);
            cyc("mem_done", 7'($urandom), 1'b1, mem_bits);
        end
        if (op != ST_OP)
            cyc("wb", 7'($urandom), 1'($urandom),
                B_RW | alu_bits(op) | ((op == LD_OP) ? B_M2R : 12'h000));
        model_cnt++;
        chk_cnt("instret");
    endtask

    logic [6:0] ops [4];

    initial begin
        ops[0] = R_OP; ops[1] = I_OP; ops[2] = LD_OP; ops[3] = ST_OP;
        reset_n   = 1'b0;
        Opcode    = 7'd0;
        mem_ready = 1'b0;
        #3;
        do_reset();

        // Directed: zero-wait R-type, load with 2+2 waits, zero-wait store.
        run_instr(R_OP, 0, 0, 1'b0);
        run_instr(LD_OP, 2, 2, 1'b0);
        run_instr(ST_OP, 0, 0, 1'b0);

        // Randomized mix with random memory latencies.
        for (int n = 0; n < 40; n++)
            run_instr(ops[$urandom_range(0, 3)], $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'b0);

        // Asynchronous reset mid-MEM of a store.
        run_instr(I_OP, 0, 0, 1'b0);
        run_instr(ST_OP, 1, 3, 1'b1);
        run_instr(R_OP, 0, 0, 1'b0);

        // Unsupported opcode: trap and stay there regardless of mem_ready.
        run_instr(BR_OP, 1, 0, 1'b0);
        for (int i = 0; i < 20; i++)
            cyc("trap", 7'($urandom), 1'($urandom), B_ILL);
        do_reset();

        // Counter wrap: 16 back-to-back I-type from zero (15, then 0).
        for (int n = 0; n < 16; n++)
            run_instr(I_OP, 0, 0, 1'b0);
        chk("instret_wrap", 32'(instret), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
